eth_tx_fcs: RTL and testbench
=============================

# eth_tx_fcs

Transmit-side frame-check-sequence inserter for the Ethernet MAC. It accepts a frame's payload bytes (destination MAC through end of data) on a valid/ready byte stream. It drives the byte-serial `crc32` stage with every byte it emits, and appends the 4-byte FCS after the last byte. It sits between the TX frame source and the preamble/PHY serializer, so downstream sees a complete frame minus preamble/SFD.

## Interface
Parameters:
- `MIN_LEN`, 60, minimum pre-FCS frame length in bytes when padding is compiled in; legal range 1–63.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  8  payload byte.
- `in_valid`  in  1  `in_data` valid.
- `in_last`  in  1  marks the final payload byte of the frame; qualified by `in_valid`.
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`.
- `out_data`  out  8  frame byte: payload, then pad, then FCS.
- `out_valid`  out  1  `out_data` valid.
- `out_last`  out  1  high on the 4th FCS byte only.
- `out_ready`  in  1  downstream accepts when `out_valid && out_ready`.

## Operation
- Output is a single registered slot. It loads whenever `load = !out_valid || out_ready`.
- State machine `st`:
  - IDLE: wait for the first byte; behaves as DATA for acceptance.
  - DATA: `in_ready = load`. Each accepted byte goes to the slot and increments `cnt`.
  - PAD: emit 0x00 until `cnt == MIN_LEN`.
  - FCS: emit 4 bytes.
- Transitions:
  - IDLE→DATA on the first accepted byte without `in_last`.
  - DATA/IDLE on an accepted byte with `in_last`: → PAD if padding is enabled and `cnt+1 < MIN_LEN`, else → FCS.
  - PAD→FCS when the last pad byte loads.
  - FCS→IDLE when FCS byte 3 loads.
- `in_ready = 0` in PAD and FCS.
- `cnt`: 6 bits, saturates at 63, cleared on entering IDLE.
- CRC:
  - The `crc32` instance gets `en = 1` on every payload or pad byte loaded into the slot, with `data_in` = that byte.
  - Its synchronous clear is driven high during `rst` and on the cycle FCS byte 3 loads.
- FCS bytes come from the CRC output `crc` (already inverted). Order is `crc[7:0]`, `crc[15:8]`, `crc[23:16]`, `crc[31:24]`.
  - A 2-bit `fcs_idx` selects the byte.
  - `crc` is stable throughout FCS because `en = 0` in that state.
- A frame of a single byte with `in_last` is legal.
- Back-to-back frames are allowed. A new frame's first byte is accepted on the cycle after FCS byte 3 loads.

## Timing
- Reset values: `out_valid = 0`, `out_last = 0`, `out_data = 0x00`, `in_ready = 0` while `rst` is high, `st = IDLE`, `cnt = 0`, `fcs_idx = 0`, CRC state all-ones.
- Latency: 1 cycle from input handshake to `out_valid`.
- With `out_ready` held high, sustained throughput is 1 byte/cycle, including across the DATA→PAD→FCS transitions (no bubbles).
- The CRC includes a byte from the edge that loads it. The first FCS byte loads one edge after the last payload/pad byte, so the CRC is complete by then.
- Backpressure: when `load = 0`, slot contents, `st`, `cnt`, `fcs_idx` and the CRC all hold.
- Reset asserted mid-frame:
  - Everything returns to reset values immediately.
  - The partially sent frame is truncated with no FCS; downstream must discard it.

## Configuration
- `ETH_TX_PAD_EN` defined: frames shorter than `MIN_LEN` are zero-padded to `MIN_LEN` bytes before the FCS. Pad bytes are included in the CRC.
- Not defined: no PAD state is generated. Frames pass through at their given length followed by the FCS; `MIN_LEN` is unused.

## Structure
- Shared `eth_pkg`:
  - state enum `eth_tx_fcs_st_t` (IDLE, DATA, PAD, FCS).
  - `ETH_MIN_FRAME = 60`, `ETH_FCS_LEN = 4`.
  - `CRC32_RESIDUE = 32'hDEBB20E3`, shared with the RX checker.
- One sub-module: the existing `crc32`, instantiated as `u_crc`. No other hierarchy.

## Test plan
- ASCII "123456789" (9 bytes), padding off, `out_ready = 1` → 13 output bytes ending `26 39 F4 CB`; `out_last` on 0xCB only.
- Same 9 bytes, padding on → 60 bytes (9 data + 51 × 0x00), then 4 FCS bytes matching a software model; 64 bytes total.
- 64-byte frame, padding on → no pad; 68 bytes out. FCS matches the model; the CRC over all 68 bytes equals `CRC32_RESIDUE`.
- Random `out_ready` toggling (50%) on a 100-byte frame → output byte sequence identical to the no-backpressure run; no dropped or duplicated bytes.
- Two back-to-back 1-byte frames (0xAA, then 0x55, padding off) → 10 bytes out. The second FCS is independent of the first, confirming the CRC was cleared.
- Assert `rst` on the 20th byte of a frame → next cycle `out_valid = 0` and `in_ready = 0`. After release, a fresh "123456789" frame yields `26 39 F4 CB`.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet MAC definitions: TX FCS state encoding, frame constants,
// and the reflected CRC-32 byte-update step.
package eth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAD  = 2'd2,
        ST_FCS  = 2'd3
    } eth_tx_fcs_st_t;

    localparam int          ETH_MIN_FRAME = 60;
    localparam int          ETH_FCS_LEN   = 4;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;

    // One byte of LSB-first CRC-32 on the raw (non-inverted) register.
    function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i])
                c = (c >> 1) ^ CRC32_POLY;
            else
                c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32.sv
// Byte-serial Ethernet CRC-32 with synchronous clear; crc output is the
// final-inverted value ready to be sent as the FCS.
module crc32
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data_in,
    output logic [31:0] crc
);

    logic [31:0] r_state;

    always_ff @(posedge clk) begin
        if (clr)
            r_state <= '1;
        else if (en)
            r_state <= crc32_next(r_state, data_in);
    end

    assign crc = ~r_state;

endmodule

// File: rtl/eth_tx_fcs.sv
// TX FCS inserter: passes payload, optionally zero-pads (ETH_TX_PAD_EN), then
// appends the 4-byte CRC-32 FCS.  State | meaning:
//   IDLE | waiting for first byte of a frame     DATA | passing payload bytes
//   PAD  | emitting 0x00 up to MIN_LEN          FCS  | emitting the 4 FCS bytes
module eth_tx_fcs
    import eth_pkg::*;
#(
    parameter int MIN_LEN = ETH_MIN_FRAME
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready
);

`ifdef ETH_TX_PAD_EN
    localparam bit PAD_ENABLED = 1'b1;
`else
    localparam bit PAD_ENABLED = 1'b0;
`endif

    localparam logic [6:0] MIN_LEN_W = 7'(MIN_LEN);
    localparam logic [1:0] FCS_LAST  = 2'(ETH_FCS_LEN - 1);

    eth_tx_fcs_st_t r_st;
    logic [5:0]     r_cnt;
    logic [1:0]     r_fcs_idx;
    logic [7:0]     r_out_data;
    logic           r_out_valid;
    logic           r_out_last;

    logic           w_load;
    logic           w_accepting;
    logic           w_in_ready;
    logic           w_in_fire;
    logic [6:0]     w_cnt_p1;
    logic [5:0]     w_cnt_sat;
    logic           w_short;
    logic           w_fcs_end;
    logic           w_crc_en;
    logic           w_crc_clr;
    logic [7:0]     w_crc_din;
    logic [31:0]    w_crc;
    logic [7:0]     w_fcs_byte;

    assign w_load      = !r_out_valid || out_ready;
    assign w_accepting = (r_st == ST_IDLE) || (r_st == ST_DATA);
    assign w_in_ready  = w_load && w_accepting && !rst;
    assign w_in_fire   = in_valid && w_in_ready;

    assign w_cnt_p1  = {1'b0, r_cnt} + 7'd1;
    assign w_cnt_sat = (r_cnt == 6'd63) ? r_cnt : w_cnt_p1[5:0];
    assign w_short   = w_cnt_p1 < MIN_LEN_W;

    assign w_fcs_end = w_load && (r_st == ST_FCS) && (r_fcs_idx == FCS_LAST);

    // CRC advances on the same edge that loads a payload/pad byte into the slot.
    assign w_crc_en  = w_load && (w_in_fire || (r_st == ST_PAD));
    assign w_crc_din = (r_st == ST_PAD) ? 8'h00 : in_data;
    assign w_crc_clr = rst || w_fcs_end;

    crc32 u_crc (
        .clk     (clk),
        .clr     (w_crc_clr),
        .en      (w_crc_en),
        .data_in (w_crc_din),
        .crc     (w_crc)
    );

    always_comb begin
        w_fcs_byte = w_crc[7:0];
        case (r_fcs_idx)
            2'd0: w_fcs_byte = w_crc[7:0];
            2'd1: w_fcs_byte = w_crc[15:8];
            2'd2: w_fcs_byte = w_crc[23:16];
            2'd3: w_fcs_byte = w_crc[31:24];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st        <= ST_IDLE;
            r_cnt       <= 6'd0;
            r_fcs_idx   <= 2'd0;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            case (r_st)
                ST_IDLE, ST_DATA: begin
                    r_out_last <= 1'b0;
                    if (in_valid) begin
                        r_out_data  <= in_data;
                        r_out_valid <= 1'b1;
                        r_cnt       <= w_cnt_sat;
                        if (in_last)
                            r_st <= (PAD_ENABLED && w_short) ? ST_PAD : ST_FCS;
                        else
                            r_st <= ST_DATA;
                    end else begin
                        r_out_valid <= 1'b0;
                    end
                end
`ifdef ETH_TX_PAD_EN
                ST_PAD: begin
                    r_out_data  <= 8'h00;
                    r_out_valid <= 1'b1;
                    r_out_last  <= 1'b0;
                    r_cnt       <= w_cnt_sat;
                    if (!w_short)
                        r_st <= ST_FCS;
                end
`endif
                ST_FCS: begin
                    r_out_data  <= w_fcs_byte;
                    r_out_valid <= 1'b1;
                    r_out_last  <= (r_fcs_idx == FCS_LAST);
                    r_fcs_idx   <= r_fcs_idx + 2'd1;
                    if (r_fcs_idx == FCS_LAST) begin
                        r_st  <= ST_IDLE;
                        r_cnt <= 6'd0;
                    end
                end
                default: begin
                    r_st        <= ST_IDLE;
                    r_cnt       <= 6'd0;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_eth_tx_fcs.sv
// Scoreboard bench for eth_tx_fcs: expected bytes come from a table-driven
// CRC-32 model and are compared as the DUT hands them downstream.
module tb_eth_tx_fcs;
    import eth_pkg::*;

    localparam int MIN_LEN = 60;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;

    int          checks   = 0;
    int          failures = 0;
    bit          bp_en    = 1'b0;
    logic [8:0]  exp_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  ref_q[$];
    logic [7:0]  frm[$];
    logic [31:0] crc_tab[256];

    eth_tx_fcs #(.MIN_LEN(MIN_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_upd(input logic [31:0] s, input logic [7:0] b);
        return crc_tab[(s[7:0] ^ b)] ^ (s >> 8);
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, expv);
        end
    endtask

    task automatic monitor_step();
        logic [8:0] e;
        if (!rst && out_valid && out_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_out observed=%02h expected=no_byte", out_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                assert ({out_last, out_data} === e) else begin
                    failures++;
                    $error("FAIL out_byte observed=last%b/%02h expected=last%b/%02h",
                           out_last, out_data, e[8], e[7:0]);
                end
            end
            rx_q.push_back(out_data);
        end
    endtask

    // Expected output for the frame in frm: payload, pad (if built in), FCS.
    task automatic push_expected();
        logic [31:0] s;
        logic [31:0] f;
        int          n;
        s = 32'hFFFF_FFFF;
        n = frm.size();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b0, frm[i]});
            s = model_upd(s, frm[i]);
        end
`ifdef ETH_TX_PAD_EN
        for (int i = n; i < MIN_LEN; i++) begin
            exp_q.push_back(9'h000);
            s = model_upd(s, 8'h00);
        end
`endif
        f = ~s;
        exp_q.push_back({1'b0, f[7:0]});
        exp_q.push_back({1'b0, f[15:8]});
        exp_q.push_back({1'b0, f[23:16]});
        exp_q.push_back({1'b1, f[31:24]});
    endtask

    // Offer frm[0..upto-1]; leaves in_valid high so frames can run back to back.
    task automatic send_frame(input int upto);
        for (int i = 0; i < upto; i++) begin
            bit hs;
            int t;
            hs = 1'b0;
            t  = 0;
            in_valid = 1'b1;
            in_data  = frm[i];
            in_last  = (i == frm.size() - 1);
            while (!hs) begin
                @(negedge clk);
                hs = in_ready;
                @(posedge clk);
                #1;
                t++;
                if (!hs && t > 2000) begin
                    check_int("in_handshake_timeout", t, 0);
                    return;
                end
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_int("drain_remaining", exp_q.size(), 0);
    endtask

    task automatic load_123456789();
        frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    endtask

    task automatic check_check_string();
`ifdef ETH_TX_PAD_EN
        check_int("len_9B_padded", rx_q.size(), MIN_LEN + 4);
`else
        check_int("len_9B", rx_q.size(), 13);
        if (rx_q.size() == 13) begin
            check_byte("fcs0", rx_q[9],  8'h26);
            check_byte("fcs1", rx_q[10], 8'h39);
            check_byte("fcs2", rx_q[11], 8'hF4);
            check_byte("fcs3", rx_q[12], 8'hCB);
        end
`endif
    endtask

    initial begin
        logic [31:0] s;

        for (int i = 0; i < 256; i++) begin
            logic [31:0] c;
            c = 32'(i);
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[i] = c;
        end

        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        fork
            forever @(negedge clk) monitor_step();
            forever begin
                @(posedge clk);
                #1;
                out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        join_none

        repeat (3) @(negedge clk);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_out_last", out_last, 1'b0);
        check_byte("rst_out_data", out_data, 8'h00);
        check_bit("rst_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // "123456789"
        rx_q.delete();
        load_123456789();
        push_expected();
        send_frame(frm.size());
        drain();
        check_check_string();

        // 64-byte frame: never padded; residue over data + FCS
        rx_q.delete();
        frm.delete();
        for (int i = 0; i < 64; i++) frm.push_back(8'($urandom_range(0, 255)));
        push_expected();
        send_frame(frm.size());
        drain();
        check_int("len_64B", rx_q.size(), 68);
        s = 32'hFFFF_FFFF;
        foreach (rx_q[i]) s = model_upd(s, rx_q[i]);
        checks++;
        assert (s === CRC32_RESIDUE) else begin
            failures++;
            $error("FAIL residue observed=%08h expected=%08h", s, CRC32_RESIDUE);
        end

        // 100-byte frame without, then with, random backpressure
        frm.delete();
        for (int i = 0; i < 100; i++) frm.push_back(8'($urandom_range(0, 255)));
        rx_q.delete();
        push_expected();
        send_frame(frm.size());
        drain();
        ref_q = rx_q;
        rx_q.delete();
        bp_en = 1'b1;
        push_expected();
        send_frame(frm.size());
        drain();
        bp_en = 1'b0;
        check_int("bp_len", rx_q.size(), 104);
        check_int("bp_len_vs_free", rx_q.size(), ref_q.size());
        if (rx_q.size() == ref_q.size())
            foreach (rx_q[i]) check_byte("bp_seq", rx_q[i], ref_q[i]);

        // two back-to-back single-byte frames
        rx_q.delete();
        frm = '{8'hAA};
        push_expected();
        send_frame(1);
        frm = '{8'h55};
        push_expected();
        send_frame(1);
        drain();
`ifdef ETH_TX_PAD_EN
        check_int("b2b_len", rx_q.size(), 2 * (MIN_LEN + 4));
`else
        check_int("b2b_len", rx_q.size(), 10);
`endif

        // reset on the 20th byte of a 30-byte frame
        frm.delete();
        for (int i = 0; i < 30; i++) frm.push_back(8'(i + 8'h40));
        push_expected();
        send_frame(19);
        in_valid = 1'b1;
        in_data  = frm[19];
        in_last  = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check_bit("midrst_out_valid", out_valid, 1'b0);
        check_bit("midrst_in_ready", in_ready, 1'b0);
        check_bit("midrst_out_last", out_last, 1'b0);
        exp_q.delete();
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rx_q.delete();
        load_123456789();
        push_expected();
        send_frame(frm.size());
        drain();
        check_check_string();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
